sram_fetch_sched: RTL and testbench
===================================

# sram_fetch_sched

Sequences the ANN's external SRAM reads for one detection pass. On a detection request it fetches the 64-entry 16-bit image and then the 1024-entry 16-bit weight set for the selected coefficient block. Each 32-bit SRAM word is unpacked into two halfword buffer writes. When both loads complete it signals `image_weights_loaded` and holds until processing finishes. It sits between the top-level ANN control and the SRAM port / on-chip image and weight buffers.

## Interface
- `READ_LAT`, 2: SRAM cycles from `sram_read` high to valid `sram_rdata`; legal range 1-7.
- `IMG_WORDS`, 32: 32-bit words per image (64 halfwords).
- `WT_WORDS`, 512: 32-bit words per weight set (1024 halfwords).
- `clk` in 1: single clock, rising edge.
- `n_rst` in 1: reset, synchronous, active-low.
- `start_detecting` in 1: request to load; sampled only in IDLE.
- `done_processing` in 1: downstream finished with buffers; sampled only in LOADED.
- `n_coef_image` in 7: coefficient block select; latched on accepted start.
- `image_base` in 16: SRAM word address of image; latched on accepted start.
- `weight_base` in 16: SRAM word address of weight block 0; latched on accepted start.
- `sram_rdata` in 32: SRAM read data; low half = even index.
- `sram_addr` out 16: SRAM word address.
- `sram_read` out 1: one-cycle read strobe.
- `buf_we` out 1: buffer write enable.
- `buf_sel` out 1: 0 = image buffer, 1 = weight buffer.
- `buf_idx` out 10: halfword index within the selected buffer.
- `buf_wdata` out 16: halfword to write.
- `busy` out 1: high in any state except IDLE and LOADED.
- `image_weights_loaded` out 1: high only in LOADED.

## Operation
- States:
  - IDLE
  - ISSUE: assert `sram_read`, drive `sram_addr`.
  - WAIT: READ_LAT-1 cycles; skipped when READ_LAT=1.
  - WR_LO: write `sram_rdata[15:0]` to index 2k; latch `sram_rdata[31:16]`.
  - WR_HI: write the latched half to index 2k+1.
  - LOADED
- Phase bit `ph`: 0 = image, 1 = weights. Word counter `k`.
- IDLE → ISSUE on `start_detecting`.
  - On that edge, latch the bases and `n_coef_image`; set ph=0, k=0.
- ISSUE → WAIT, or → WR_LO if READ_LAT=1.
- WAIT → WR_LO when the wait count expires.
- WR_LO → WR_HI, always.
- WR_HI → ISSUE (k+1) when k < last.
- WR_HI → ISSUE (ph=1, k=0) at image end.
- WR_HI → LOADED at weight end.
- LOADED → IDLE on `done_processing`.
- Address arithmetic, 16-bit, wraps mod 2^16:
  - image: `image_base + k`
  - weights: `weight_base + {coef,9'b0} + k`
- `buf_idx` = {k, lo/hi bit}, zero-extended to 10 bits. `buf_sel` = ph.
- `start_detecting` is ignored outside IDLE; `done_processing` is ignored outside LOADED.
- Input changes after the accepted start do not affect the current pass.
- A start held high across LOADED→IDLE restarts one cycle after entering IDLE, since IDLE lasts at least one cycle.

## Timing
- Reset: state = IDLE; all outputs 0 (`sram_addr`, `buf_idx`, `buf_wdata` included); counters and latches cleared.
- Reset mid-pass: IDLE on the next edge; no further reads or writes.
- Outputs are registered-state decodes, so they are valid in the cycle the state is entered.
- ISSUE at cycle t → WR_LO at t+READ_LAT (data valid then) → WR_HI at t+READ_LAT+1 → next ISSUE at t+READ_LAT+2.
- Per word: READ_LAT+2 cycles.
- Total from the start edge to `image_weights_loaded` = (IMG_WORDS+WT_WORDS)·(READ_LAT+2) cycles. Defaults: 544·4 = 2176.
- Each output is high exactly one cycle per occurrence: `sram_read` once per word; `buf_we` twice per word.
- `buf_we`, `sram_read` and `busy` are never high in IDLE or LOADED.

## Structure
- Package `sram_sched_pkg`:
  - state enum `sched_state_t` (IDLE, ISSUE, WAIT, WR_LO, WR_HI, LOADED)
  - default constants IMG_WORDS, WT_WORDS
  - `COEF_SHIFT` = 9
- One sub-module is natural: `sram_lat_counter`, a loadable down-counter for WAIT with an `expired` flag.
- FSM, word counter and address adder stay in the top.

## Test plan
- Basic pass: reset; image_base=0x0100, weight_base=0x2000, coef=3.
  - First ISSUE `sram_addr`=0x0100.
  - First weight ISSUE `sram_addr`=0x2600.
  - `image_weights_loaded` rises exactly 2176 cycles after the start edge.
- Unpack: SRAM returns 0xBEEF_CAFE for image word 5.
  - `buf_idx`=10 gets 0xCAFE; `buf_idx`=11 gets 0xBEEF; `buf_sel`=0.
- Wrap: weight_base=0xFF00, coef=127.
  - First weight `sram_addr`=0xFD00; the last weight address wraps correctly mod 2^16.
- Ignored inputs:
  - `done_processing` pulsed mid-load → no effect.
  - `start_detecting` pulsed in LOADED → no effect.
  - `done_processing` in LOADED → IDLE next cycle; `loaded`=0.
- Reset mid-pass: drop `n_rst` during weight word 100.
  - Next cycle: all outputs 0, state IDLE, no `buf_we`.
  - A new start runs a full pass from image word 0.
- READ_LAT=1 build: no WAIT cycles; 3 cycles per word; total 1632 cycles.

Source files
------------

// File: rtl/sram_fetch_sched_pkg.sv
// Shared types and default sizing for the detection-pass SRAM fetch scheduler.
package sram_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      WR_LO,
      WR_HI,
      LOADED
   } sched_state_t;

   localparam int IMG_WORDS  = 32;
   localparam int WT_WORDS   = 512;
   localparam int READ_LAT   = 2;
   localparam int COEF_SHIFT = 9;

endpackage

// File: rtl/sram_fetch_sched_if.sv
// SRAM read port plus image/weight buffer write port seen by the scheduler.
interface sram_fetch_sched_if;

   logic [15:0] sram_addr;
   logic        sram_read;
   logic [31:0] sram_rdata;
   logic        buf_we;
   logic        buf_sel;
   logic [9:0]  buf_idx;
   logic [15:0] buf_wdata;

   modport master (
      output sram_addr, sram_read, buf_we, buf_sel, buf_idx, buf_wdata,
      input  sram_rdata
   );

   modport slave (
      input  sram_addr, sram_read, buf_we, buf_sel, buf_idx, buf_wdata,
      output sram_rdata
   );

endinterface

// File: rtl/sram_fetch_sched_lat_counter.sv
// Loadable down-counter timing the SRAM read latency; expired when it reaches zero.
module sram_lat_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt;

   // load on a new read, otherwise count down and park at zero
   always_ff @(posedge clk) begin
      if (!n_rst) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (cnt != '0) cnt <= cnt - 1'b1;
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/sram_fetch_sched.sv
// Fetches the image then the selected weight block from SRAM into the on-chip
// buffers, unpacking each 32-bit word into two halfword writes.
//
// state  | meaning
// IDLE   | waiting for start_detecting
// ISSUE  | one-cycle read strobe with word address
// WAIT   | READ_LAT-1 cycles of read latency (absent when READ_LAT=1)
// WR_LO  | write low half to index 2k, capture high half
// WR_HI  | write captured high half to index 2k+1, advance word/phase
// LOADED | both buffers filled, waiting for done_processing
module sram_fetch_sched
   import sram_sched_pkg::*;
#(
   parameter int READ_LAT  = sram_sched_pkg::READ_LAT,
   parameter int IMG_WORDS = sram_sched_pkg::IMG_WORDS,
   parameter int WT_WORDS  = sram_sched_pkg::WT_WORDS
) (
   input  logic                      clk,
   input  logic                      n_rst,
   input  logic                      start_detecting,
   input  logic                      done_processing,
   input  logic [6:0]                n_coef_image,
   input  logic [15:0]               image_base,
   input  logic [15:0]               weight_base,
   output logic                      busy,
   output logic                      image_weights_loaded,
   sram_fetch_sched_if.master        bus
);

   localparam int K_W   = $clog2(WT_WORDS);
   localparam int LAT_W = 3;
   // WAIT lasts READ_LAT-1 cycles, so the counter starts one below that
   localparam logic [LAT_W-1:0] LAT_LOAD = (READ_LAT > 1) ? LAT_W'(READ_LAT - 2) : '0;
   localparam logic [K_W-1:0]   IMG_LAST = K_W'(IMG_WORDS - 1);
   localparam logic [K_W-1:0]   WT_LAST  = K_W'(WT_WORDS - 1);

   sched_state_t state, state_nx;
   logic         ph;
   logic [K_W-1:0] k;
   logic [6:0]   coef_q;
   logic [15:0]  img_base_q, wt_base_q, hi_q;
   logic [15:0]  img_addr, wt_addr;
   logic [K_W-1:0] k_last;
   logic         lat_expired;

   sram_lat_counter #(.W(LAT_W)) u_lat (
      .clk      (clk),
      .n_rst    (n_rst),
      .load     (state == ISSUE),
      .load_val (LAT_LOAD),
      .expired  (lat_expired)
   );

   assign k_last   = ph ? WT_LAST : IMG_LAST;
   assign img_addr = img_base_q + 16'(k);
   assign wt_addr  = wt_base_q + (16'(coef_q) << COEF_SHIFT) + 16'(k);

   // state register
   always_ff @(posedge clk) begin
      if (!n_rst) state <= IDLE;
      else state <= state_nx;
   end

   // next-state decode
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start_detecting) state_nx = ISSUE;
         ISSUE:   state_nx = (READ_LAT == 1) ? WR_LO : WAIT;
         WAIT:    if (lat_expired) state_nx = WR_LO;
         WR_LO:   state_nx = WR_HI;
         WR_HI:   state_nx = (ph && (k == k_last)) ? LOADED : ISSUE;
         LOADED:  if (done_processing) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // pass context latched at start, word/phase counter, captured high half
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         ph         <= 1'b0;
         k          <= '0;
         coef_q     <= '0;
         img_base_q <= '0;
         wt_base_q  <= '0;
         hi_q       <= '0;
      end else begin
         case (state)
            IDLE: if (start_detecting) begin
               coef_q     <= n_coef_image;
               img_base_q <= image_base;
               wt_base_q  <= weight_base;
               ph         <= 1'b0;
               k          <= '0;
            end
            WR_LO: hi_q <= bus.sram_rdata[31:16];
            WR_HI: begin
               if (k != k_last) k <= k + 1'b1;
               else if (!ph) begin
                  ph <= 1'b1;
                  k  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // outputs are pure decodes of the registered state; zero when not active
   always_comb begin
      bus.sram_read = 1'b0;
      bus.sram_addr = '0;
      bus.buf_we    = 1'b0;
      bus.buf_sel   = 1'b0;
      bus.buf_idx   = '0;
      bus.buf_wdata = '0;
      case (state)
         ISSUE: begin
            bus.sram_read = 1'b1;
            bus.sram_addr = ph ? wt_addr : img_addr;
         end
         WR_LO: begin
            bus.buf_we    = 1'b1;
            bus.buf_sel   = ph;
            bus.buf_idx   = 10'({k, 1'b0});
            bus.buf_wdata = bus.sram_rdata[15:0];
         end
         WR_HI: begin
            bus.buf_we    = 1'b1;
            bus.buf_sel   = ph;
            bus.buf_idx   = 10'({k, 1'b1});
            bus.buf_wdata = hi_q;
         end
         default: ;
      endcase
   end

   assign busy                 = (state != IDLE) && (state != LOADED);
   assign image_weights_loaded = (state == LOADED);

endmodule

// File: tb/tb_sram_fetch_sched.sv
// Directed bench for sram_fetch_sched: default-latency instance plus a READ_LAT=1 instance.
module tb_sram_fetch_sched;
   import sram_sched_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        n_rst, start, start2, done, clr;
   logic [6:0]  coef;
   logic [15:0] ib, wb;
   logic        busy1, loaded1, busy2, loaded2;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   sram_fetch_sched_if bus1 ();
   sram_fetch_sched_if bus2 ();

   sram_fetch_sched dut1 (
      .clk(clk), .n_rst(n_rst), .start_detecting(start), .done_processing(done),
      .n_coef_image(coef), .image_base(ib), .weight_base(wb),
      .busy(busy1), .image_weights_loaded(loaded1), .bus(bus1)
   );

   sram_fetch_sched #(.READ_LAT(1)) dut2 (
      .clk(clk), .n_rst(n_rst), .start_detecting(start2), .done_processing(done),
      .n_coef_image(coef), .image_base(ib), .weight_base(wb),
      .busy(busy2), .image_weights_loaded(loaded2), .bus(bus2)
   );

   // SRAM contents: address-derived pattern with one planted word
   function automatic logic [31:0] mem(input logic [15:0] a);
      if (a == 16'h0105) return 32'hBEEF_CAFE;
      return {a ^ 16'hA5A5, a};
   endfunction

   // SRAM models: data valid exactly READ_LAT cycles after the strobe, junk otherwise
   logic [15:0] cap1, cap2;
   int lat1 = 0;
   int lat2 = 0;
   always @(posedge clk) begin
      if (bus1.sram_read) begin cap1 <= bus1.sram_addr; lat1 <= 2; end
      else if (lat1 != 0) lat1 <= lat1 - 1;
      if (bus2.sram_read) begin cap2 <= bus2.sram_addr; lat2 <= 1; end
      else if (lat2 != 0) lat2 <= lat2 - 1;
   end
   assign bus1.sram_rdata = (lat1 == 1) ? mem(cap1) : 32'hDEAD_DEAD;
   assign bus2.sram_rdata = (lat2 == 1) ? mem(cap2) : 32'hDEAD_DEAD;

   // expected read address sequence for the current dut1 pass
   logic [15:0] exp_ib, exp_wb;
   logic [6:0]  exp_coef;
   function automatic logic [15:0] exp_addr(input int n);
      if (n < 32) return exp_ib + 16'(n);
      return exp_wb + (16'(exp_coef) << 9) + 16'(n - 32);
   endfunction

   // dut1 monitor
   int rd_cnt, we_cnt, addr_err, data_err, viol;
   logic [15:0] rd_addr [0:543];
   logic [15:0] w10, w11;
   logic prev_rd1;
   int wi;
   logic hb;
   logic [9:0] ei;
   logic [31:0] d1;
   always @(negedge clk) begin
      if (clr) begin
         rd_cnt <= 0; we_cnt <= 0; addr_err <= 0; data_err <= 0; viol <= 0;
      end else begin
         if (bus1.sram_read) begin
            if (rd_cnt < 544) rd_addr[rd_cnt] <= bus1.sram_addr;
            if (bus1.sram_addr !== exp_addr(rd_cnt)) addr_err <= addr_err + 1;
            rd_cnt <= rd_cnt + 1;
         end
         if (bus1.buf_we) begin
            wi = rd_cnt - 1;
            hb = we_cnt[0];
            ei = {9'((wi >= 32) ? wi - 32 : wi), hb};
            d1 = mem(cap1);
            if (bus1.buf_sel !== 1'(wi >= 32) || bus1.buf_idx !== ei ||
                bus1.buf_wdata !== (hb ? d1[31:16] : d1[15:0]))
               data_err <= data_err + 1;
            if (!bus1.buf_sel && bus1.buf_idx == 10'd10) w10 <= bus1.buf_wdata;
            if (!bus1.buf_sel && bus1.buf_idx == 10'd11) w11 <= bus1.buf_wdata;
            we_cnt <= we_cnt + 1;
         end
         if ((bus1.sram_read || bus1.buf_we) && !busy1) viol <= viol + 1;
         if (busy1 && loaded1) viol <= viol + 1;
         if (bus1.sram_read && prev_rd1) viol <= viol + 1;
      end
      prev_rd1 <= bus1.sram_read;
   end

   // dut2 monitor: counts and unpacked data
   int rd_cnt2 = 0;
   int we_cnt2 = 0;
   int data_err2 = 0;
   logic [31:0] d2;
   always @(negedge clk) begin
      if (bus2.sram_read) rd_cnt2 <= rd_cnt2 + 1;
      if (bus2.buf_we) begin
         d2 = mem(cap2);
         if (bus2.buf_wdata !== (we_cnt2[0] ? d2[31:16] : d2[15:0])) data_err2 <= data_err2 + 1;
         we_cnt2 <= we_cnt2 + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_pass(input logic [15:0] i, input logic [15:0] w, input logic [6:0] c);
      ib = i; wb = w; coef = c;
      exp_ib = i; exp_wb = w; exp_coef = c;
      clr = 1'b1;
      step(1);
      clr = 1'b0;
   endtask

   // start a pass; optionally disturb inputs and pulse done mid-load
   task automatic run_pass(input bit poke, output int n);
      start = 1'b1;
      step(1);
      start = 1'b0;
      if (poke) begin ib = 16'h7777; wb = 16'h1234; coef = 7'd99; end
      n = 0;
      while (!loaded1 && n < 3000) begin
         step(1);
         n++;
         done = poke && (n == 100);
      end
      done = 1'b0;
   endtask

   int n, snap_rd, snap_we;

   initial begin
      n_rst = 1'b0; start = 1'b0; start2 = 1'b0; done = 1'b0; clr = 1'b1;
      coef = '0; ib = '0; wb = '0;
      exp_ib = '0; exp_wb = '0; exp_coef = '0;
      step(3);
      chk("rst_read",   32'(bus1.sram_read), 0);
      chk("rst_addr",   32'(bus1.sram_addr), 0);
      chk("rst_we",     32'(bus1.buf_we), 0);
      chk("rst_idx",    32'(bus1.buf_idx), 0);
      chk("rst_wdata",  32'(bus1.buf_wdata), 0);
      chk("rst_busy",   32'(busy1), 0);
      chk("rst_loaded", 32'(loaded1), 0);
      n_rst = 1'b1;

      // basic pass with mid-load input disturbance and stray done pulse
      set_pass(16'h0100, 16'h2000, 7'd3);
      run_pass(1'b1, n);
      chk("p1_cycles",    32'(n), 2176);
      chk("p1_reads",     32'(rd_cnt), 544);
      chk("p1_writes",    32'(we_cnt), 1088);
      chk("p1_addr_err",  32'(addr_err), 0);
      chk("p1_data_err",  32'(data_err), 0);
      chk("p1_viol",      32'(viol), 0);
      chk("p1_first_img", 32'(rd_addr[0]), 32'h0100);
      chk("p1_first_wt",  32'(rd_addr[32]), 32'h2600);
      chk("p1_last_wt",   32'(rd_addr[543]), 32'h27FF);
      chk("unpack_lo",    32'(w10), 32'hCAFE);
      chk("unpack_hi",    32'(w11), 32'hBEEF);

      // start while LOADED is ignored
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(2);
      chk("ld_ign_loaded", 32'(loaded1), 1);
      chk("ld_ign_busy",   32'(busy1), 0);
      chk("ld_ign_reads",  32'(rd_cnt), 544);

      // done releases to IDLE next cycle
      done = 1'b1;
      step(1);
      done = 1'b0;
      chk("done_loaded", 32'(loaded1), 0);
      chk("done_busy",   32'(busy1), 0);
      chk("done_state",  32'(dut1.state), 32'(IDLE));
      step(2);
      chk("idle_reads",  32'(rd_cnt), 544);

      // wrap-around pass
      set_pass(16'hFFF0, 16'hFF00, 7'd127);
      run_pass(1'b0, n);
      chk("p2_cycles",    32'(n), 2176);
      chk("p2_addr_err",  32'(addr_err), 0);
      chk("p2_data_err",  32'(data_err), 0);
      chk("p2_last_img",  32'(rd_addr[31]), 32'h000F);
      chk("p2_first_wt",  32'(rd_addr[32]), 32'hFD00);
      chk("p2_last_wt",   32'(rd_addr[543]), 32'hFEFF);

      // start held across LOADED->IDLE restarts after one IDLE cycle
      set_pass(16'h0040, 16'h1000, 7'd5);
      start = 1'b1;
      done = 1'b1;
      step(1);
      done = 1'b0;
      chk("hold_idle_loaded", 32'(loaded1), 0);
      chk("hold_idle_busy",   32'(busy1), 0);
      step(1);
      start = 1'b0;
      chk("hold_restart_rd",  32'(bus1.sram_read), 1);
      chk("hold_restart_adr", 32'(bus1.sram_addr), 32'h0040);

      // reset during weight word 100
      n = 0;
      while (rd_cnt < 133 && n < 1000) begin step(1); n++; end
      chk("reach_wt100", 32'(rd_cnt), 133);
      step(1);
      n_rst = 1'b0;
      step(1);
      chk("mid_rst_read",   32'(bus1.sram_read), 0);
      chk("mid_rst_addr",   32'(bus1.sram_addr), 0);
      chk("mid_rst_we",     32'(bus1.buf_we), 0);
      chk("mid_rst_idx",    32'(bus1.buf_idx), 0);
      chk("mid_rst_wdata",  32'(bus1.buf_wdata), 0);
      chk("mid_rst_busy",   32'(busy1), 0);
      chk("mid_rst_state",  32'(dut1.state), 32'(IDLE));
      snap_rd = rd_cnt;
      snap_we = we_cnt;
      step(3);
      chk("rst_hold_reads",  32'(rd_cnt), 32'(snap_rd));
      chk("rst_hold_writes", 32'(we_cnt), 32'(snap_we));
      n_rst = 1'b1;
      set_pass(16'h0040, 16'h1000, 7'd5);
      run_pass(1'b0, n);
      chk("p3_cycles",    32'(n), 2176);
      chk("p3_reads",     32'(rd_cnt), 544);
      chk("p3_first_img", 32'(rd_addr[0]), 32'h0040);
      chk("p3_addr_err",  32'(addr_err), 0);
      chk("p3_data_err",  32'(data_err), 0);

      // READ_LAT=1 instance
      ib = 16'h0000; wb = 16'h4000; coef = 7'd0;
      start2 = 1'b1;
      step(1);
      start2 = 1'b0;
      n = 0;
      while (!loaded2 && n < 3000) begin step(1); n++; end
      chk("lat1_cycles",   32'(n), 1632);
      chk("lat1_reads",    32'(rd_cnt2), 544);
      chk("lat1_writes",   32'(we_cnt2), 1088);
      chk("lat1_data_err", 32'(data_err2), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
